st_bus_ctrl: RTL and testbench
==============================

# st_bus_ctrl

Bus-cycle responder for the Atari ST core. It sits directly downstream of the 68000-compatible CPU bus wrapper and consumes its `as_n`, `uds_n`, `lds_n`, `rw_n`, `fc` and `addr` strobes. It decodes each cycle into a region and answers with `dtack_n`, `vpa_n` or `berr`. It also inserts per-region wait states and raises bus error on protection violations and on unacknowledged cycles.

## Interface
Parameters:
- `RAM_WAIT`, 0: extra phi2 edges before DTACK for RAM cycles.
- `ROM_WAIT`, 1: extra phi2 edges before DTACK for ROM cycles.
- `TIMEOUT`, 64: phi2 edges without acknowledge before `berr`; range 2..255.
- `RAM_TOP`, 24'h400000: first address above RAM.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset_n` in 1: reset, synchronous, active-low.
- `phi1` in 1: CPU phase-1 clock enable, one `clk` wide.
- `phi2` in 1: CPU phase-2 clock enable, one `clk` wide.
- `as_n` in 1: address strobe.
- `uds_n` in 1: upper data strobe.
- `lds_n` in 1: lower data strobe.
- `rw_n` in 1: 1 = read.
- `fc` in 3: function code.
- `addr` in 24: byte address; bit 0 ignored.
- `ext_dtack_n` in 1: acknowledge from I/O devices that time themselves.
- `dtack_n` out 1: data acknowledge.
- `vpa_n` out 1: valid peripheral address (6800 cycle or autovector).
- `berr` out 1: bus error, active-high.
- `region` out 2: 0 none, 1 RAM, 2 ROM, 3 I/O; held for the duration of the cycle.

## Operation
Decode is evaluated at cycle start, in priority order:
1. Interrupt acknowledge (IACK): `fc==3'b111` and `addr[19:16]==4'hF` → response VPA, region 0.
2. User-mode protection: `fc[2]==0` and (`addr<24'h000800` or `addr>=24'hFF8000`) → response BERR.
3. RAM: `addr<RAM_TOP` → response DTACK after `RAM_WAIT`, region 1.
4. ROM: `addr[23:16]` in FC..FE → response DTACK after `ROM_WAIT`, region 2. Writes to ROM → response BERR.
5. I/O: `FFFC00..FFFDFF` (6850 ACIAs) → response VPA, region 3.
6. Other I/O: `addr>=FF8000` → response EXT, region 3; waits for `ext_dtack_n`.
7. Anything else → response NONE; no acknowledge, ends in timeout.

State machine: IDLE, WAIT, ACK, ERR.
- IDLE: on a phi2 with `as_n==0` and (`uds_n==0` or `lds_n==0` or `rw_n==1`), latch decode and load `wcnt` with the region's wait value and `tcnt` with 1.
  - Response DTACK with wait 0, or VPA → ACK, outputs asserted on that same edge.
  - Response BERR → ERR, `berr` asserted on that same edge.
  - Otherwise → WAIT.
- WAIT, on each phi2:
  - `wcnt` decrements. DTACK response → ACK when `wcnt` reaches 0.
  - EXT response → ACK on the phi2 where `ext_dtack_n==0`.
  - `tcnt` increments. `tcnt==TIMEOUT` → ERR.
  - Acknowledge and timeout on the same phi2: acknowledge wins.
- ACK / ERR: outputs are held, independent of phi, until `as_n` is seen high.
- Any state: `as_n==1` → IDLE on the next `clk`. `dtack_n`, `vpa_n` and `berr` are deasserted, `region` is cleared to 0, and both counters are cleared. This is the abort path for cycles cut short by the CPU or by bus grant.
- `tcnt` saturates at `TIMEOUT`. `wcnt` does not wrap below 0.

## Timing
- Reset values: `dtack_n=1`, `vpa_n=1`, `berr=0`, `region=0`, state IDLE, counters 0. Reset takes effect on the first `clk` edge with `reset_n==0`, including mid-cycle.
- All outputs are registered. `phi1` is accepted but only qualifies nothing; all transitions happen on `phi2` except the `as_n` release.
- DTACK latency: asserted on the (wait+1)-th phi2 edge with `as_n` low. With `RAM_WAIT=0` it is the first such edge, so the wrapper's phi2 state-4 check sees DTACK without stall.
- Release: outputs deassert within 1 `clk` of `as_n` rising. They never overlap the next cycle's first phi2.
- Timeout: `berr` rises on the `TIMEOUT`-th phi2 edge after cycle start.
- `ext_dtack_n` is sampled only on phi2 in WAIT.

## Test plan
- RAM read at `addr=24'h001000`, `RAM_WAIT=0` → `dtack_n` low on the first phi2 with `as_n` low; `region=1`; release 1 `clk` after `as_n` high.
- ROM read at `24'hFC0010`, `ROM_WAIT=1` → `dtack_n` low on the 2nd phi2. ROM write at the same address → `berr=1` on the 1st phi2 with `dtack_n` staying 1.
- IACK with `fc=7` and `addr=24'hFFFFF9` (level 4) → `vpa_n` low on the 1st phi2. ACIA access at `24'hFFFC00` → `vpa_n` low with `region=3`.
- User-mode (`fc=3'b001`) read of `24'h000400` → `berr` on the 1st phi2. Unmapped `24'hE00000` → `berr` exactly on phi2 #64.
- EXT cycle at `24'hFF8800` with `ext_dtack_n` pulled low on phi2 #64 → DTACK wins over timeout, `berr` stays 0.
- `as_n` raised mid-WAIT, and separately `reset_n` pulled low mid-ACK → all outputs return to reset values on the next `clk`, and the next cycle decodes cleanly.

Source files
------------

// File: rtl/st_bus_ctrl.sv
// -----------------------------------------------------------------------------
// st_bus_ctrl
//
// Bus-cycle responder for the Atari ST core. Sits behind the 68000 bus wrapper,
// decodes each bus cycle into a region and answers it with DTACK, VPA or BERR.
// It inserts per-region wait states, and it raises a bus error in two cases:
// protection violations and cycles that nothing acknowledges.
//
// Ports
//   clk          system clock (single domain)
//   reset_n      synchronous active-low reset
//   phi1, phi2   CPU phase clock enables, one clk wide. phi1 is accepted but unused.
//   as_n         address strobe
//   uds_n, lds_n upper / lower data strobes
//   rw_n         1 = read
//   fc[2:0]      function code
//   addr[23:0]   byte address. Bit 0 is ignored.
//   ext_dtack_n  acknowledge from self-timed I/O devices
//   dtack_n      data acknowledge
//   vpa_n        valid peripheral address (6800 cycle / autovector)
//   berr         bus error, active-high
//   region[1:0]  0 none, 1 RAM, 2 ROM, 3 I/O. Held for the whole cycle.
// -----------------------------------------------------------------------------
module st_bus_ctrl #(
    parameter int          RAM_WAIT = 0,
    parameter int          ROM_WAIT = 1,
    parameter int          TIMEOUT  = 64,
    parameter logic [23:0] RAM_TOP  = 24'h400000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        phi1,
    input  logic        phi2,
    input  logic        as_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic        rw_n,
    input  logic [2:0]  fc,
    input  logic [23:0] addr,
    input  logic        ext_dtack_n,
    output logic        dtack_n,
    output logic        vpa_n,
    output logic        berr,
    output logic [1:0]  region
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Kind of answer the decoded cycle expects.
    localparam logic [2:0] RSP_NONE  = 3'd0;
    localparam logic [2:0] RSP_DTACK = 3'd1;
    localparam logic [2:0] RSP_VPA   = 3'd2;
    localparam logic [2:0] RSP_BERR  = 3'd3;
    localparam logic [2:0] RSP_EXT   = 3'd4;

    localparam logic [7:0] L_TIMEOUT  = 8'(TIMEOUT);
    localparam logic [7:0] L_RAM_WAIT = 8'(RAM_WAIT);
    localparam logic [7:0] L_ROM_WAIT = 8'(ROM_WAIT);

    logic [1:0]  r_state;
    logic [2:0]  r_rsp;
    logic [7:0]  r_wcnt;
    logic [7:0]  r_tcnt;
    logic        r_dtack_n;
    logic        r_vpa_n;
    logic        r_berr;
    logic [1:0]  r_region;

    logic [23:0] w_addr;
    logic [2:0]  w_rsp;
    logic [1:0]  w_region;
    logic [7:0]  w_wait;
    logic        w_start;
    logic [7:0]  w_wcnt_next;
    logic [7:0]  w_tcnt_next;
    logic        w_ack;
    logic        w_timeout;
    logic        w_unused;

    // phi1 qualifies nothing and addr[0] is not part of a word address.
    assign w_unused = &{1'b0, phi1, addr[0]};

    // A cycle is real once AS is low and there is a read, or a write with
    // at least one data strobe. A write whose strobes are still high must not start yet.
    assign w_start = !as_n && (!uds_n || !lds_n || rw_n);

    // Address decode. The branches are in priority order.
    always_comb begin
        w_addr   = {addr[23:1], 1'b0};
        w_rsp    = RSP_NONE;
        w_region = 2'd0;
        w_wait   = 8'd0;
        if (fc == 3'b111 && addr[19:16] == 4'hF) begin
            // Interrupt acknowledge: autovector through VPA.
            w_rsp = RSP_VPA;
        end else if (!fc[2] && (w_addr < 24'h000800 || w_addr >= 24'hFF8000)) begin
            // User mode may touch neither the vector page nor I/O space.
            w_rsp = RSP_BERR;
        end else if (w_addr < RAM_TOP) begin
            w_rsp    = RSP_DTACK;
            w_region = 2'd1;
            w_wait   = L_RAM_WAIT;
        end else if (addr[23:16] >= 8'hFC && addr[23:16] <= 8'hFE) begin
            w_region = 2'd2;
            w_wait   = L_ROM_WAIT;
            w_rsp    = rw_n ? RSP_DTACK : RSP_BERR;
        end else if (w_addr >= 24'hFFFC00 && w_addr <= 24'hFFFDFF) begin
            // The 6850 ACIAs are 6800-style peripherals.
            w_rsp    = RSP_VPA;
            w_region = 2'd3;
        end else if (w_addr >= 24'hFF8000) begin
            w_rsp    = RSP_EXT;
            w_region = 2'd3;
        end
    end

    // Both counters clamp: wcnt at 0, tcnt at TIMEOUT.
    assign w_wcnt_next = (r_wcnt != 8'd0) ? r_wcnt - 8'd1 : 8'd0;
    assign w_tcnt_next = (r_tcnt < L_TIMEOUT) ? r_tcnt + 8'd1 : r_tcnt;

    // Acknowledge is checked before timeout.
    // If both happen on the same phi2, the acknowledge wins.
    assign w_ack     = (r_rsp == RSP_DTACK && w_wcnt_next == 8'd0) ||
                       (r_rsp == RSP_EXT && !ext_dtack_n);
    assign w_timeout = (w_tcnt_next == L_TIMEOUT);

    always_ff @(posedge clk) begin
        if (!reset_n || as_n) begin
            // Reset and AS release share one path.
            // When the CPU drops AS, the cycle ends at once (abort, bus grant).
            r_state   <= S_IDLE;
            r_rsp     <= RSP_NONE;
            r_wcnt    <= 8'd0;
            r_tcnt    <= 8'd0;
            r_dtack_n <= 1'b1;
            r_vpa_n   <= 1'b1;
            r_berr    <= 1'b0;
            r_region  <= 2'd0;
        end else if (phi2) begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_rsp    <= w_rsp;
                        r_region <= w_region;
                        r_wcnt   <= w_wait;
                        r_tcnt   <= 8'd1;
                        if (w_rsp == RSP_VPA) begin
                            r_state <= S_ACK;
                            r_vpa_n <= 1'b0;
                        end else if (w_rsp == RSP_DTACK && w_wait == 8'd0) begin
                            // Zero-wait DTACK lands on the first phi2.
                            // The wrapper sees it without a stall.
                            r_state   <= S_ACK;
                            r_dtack_n <= 1'b0;
                        end else if (w_rsp == RSP_BERR) begin
                            r_state <= S_ERR;
                            r_berr  <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_wcnt <= w_wcnt_next;
                    r_tcnt <= w_tcnt_next;
                    if (w_ack) begin
                        r_state   <= S_ACK;
                        r_dtack_n <= 1'b0;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        r_berr  <= 1'b1;
                    end
                end
                default: begin
                    // ACK / ERR: hold the answer until AS goes high.
                end
            endcase
        end
    end

    assign dtack_n = r_dtack_n;
    assign vpa_n   = r_vpa_n;
    assign berr    = r_berr;
    assign region  = r_region;

endmodule

// File: tb/tb_st_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_st_bus_ctrl
//
// Self-checking bench for st_bus_ctrl. Each bus cycle is predicted by a
// reference model written in terms of "which answer, on which phi2 edge".
// That prediction is compared against what the DUT shows on its outputs.
// Directed cycles come first, then randomized cycles.
// -----------------------------------------------------------------------------
module tb_st_bus_ctrl;

    localparam int RAM_WAIT = 0;
    localparam int ROM_WAIT = 1;
    localparam int TIMEOUT  = 64;

    // Output triple {dtack_n, vpa_n, berr}
    localparam logic [2:0] T_IDLE  = 3'b110;
    localparam logic [2:0] T_DTACK = 3'b010;
    localparam logic [2:0] T_VPA   = 3'b100;
    localparam logic [2:0] T_BERR  = 3'b111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        phi1 = 1'b0;
    logic        phi2 = 1'b0;
    logic        as_n = 1'b1;
    logic        uds_n = 1'b1;
    logic        lds_n = 1'b1;
    logic        rw_n = 1'b1;
    logic [2:0]  fc = 3'd0;
    logic [23:0] addr = 24'd0;
    logic        ext_dtack_n = 1'b1;
    logic        dtack_n;
    logic        vpa_n;
    logic        berr;
    logic [1:0]  region;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    st_bus_ctrl #(
        .RAM_WAIT (RAM_WAIT),
        .ROM_WAIT (ROM_WAIT),
        .TIMEOUT  (TIMEOUT),
        .RAM_TOP  (24'h400000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .phi1        (phi1),
        .phi2        (phi2),
        .as_n        (as_n),
        .uds_n       (uds_n),
        .lds_n       (lds_n),
        .rw_n        (rw_n),
        .fc          (fc),
        .addr        (addr),
        .ext_dtack_n (ext_dtack_n),
        .dtack_n     (dtack_n),
        .vpa_n       (vpa_n),
        .berr        (berr),
        .region      (region)
    );

    initial forever #5 clk = ~clk;

    // The CPU phase enables run on a 4-clk period: phi1 in phase 0, phi2 in phase 2.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph   = (ph + 1) % 4;
            phi1 = (ph == 0);
            phi2 = (ph == 2);
        end
    end

    // Watchdog: if the bench itself ever hangs, stop with a failure.
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model. For one cycle it predicts:
    //   - the answer,
    //   - the phi2 edge (counted from cycle start) where the answer appears,
    //   - the region (-1 = not checked).
    // ext_at is the phi2 edge from which ext_dtack_n is held low (0 = never).
    function automatic void model(input logic [2:0] f, input logic [23:0] a, input logic rw,
                                  input int ext_at, output logic [2:0] trip,
                                  output int edge_no, output int reg_exp);
        int ad;
        int e;
        ad = int'(a) & 32'h00FF_FFFE;
        e  = (ext_at < 2) ? 2 : ext_at;
        if (f == 3'd7 && a[19:16] == 4'hF) begin
            trip = T_VPA;  edge_no = 1; reg_exp = 0;
        end else if (f < 3'd4 && (ad < 'h800 || ad >= 'hFF8000)) begin
            trip = T_BERR; edge_no = 1; reg_exp = -1;
        end else if (ad < 'h400000) begin
            trip = T_DTACK; edge_no = RAM_WAIT + 1; reg_exp = 1;
        end else if (ad >= 'hFC0000 && ad < 'hFF0000) begin
            if (rw) begin
                trip = T_DTACK; edge_no = ROM_WAIT + 1; reg_exp = 2;
            end else begin
                trip = T_BERR;  edge_no = 1; reg_exp = -1;
            end
        end else if (ad >= 'hFFFC00 && ad < 'hFFFE00) begin
            trip = T_VPA; edge_no = 1; reg_exp = 3;
        end else if (ad >= 'hFF8000) begin
            reg_exp = 3;
            if (ext_at != 0 && e <= TIMEOUT) begin
                trip = T_DTACK; edge_no = e;
            end else begin
                trip = T_BERR;  edge_no = TIMEOUT;
            end
        end else begin
            trip = T_BERR; edge_no = TIMEOUT; reg_exp = 0;
        end
    endfunction

    // Raise AS and check that everything is back to idle one clk later.
    task automatic release_check(input string tag);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; ext_dtack_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, " release"}, {dtack_n, vpa_n, berr, region}, 5'b11000);
    endtask

    // Run one full bus cycle. The caller is at a negedge.
    task automatic do_cycle(input string tag, input logic [2:0] f, input logic [23:0] a,
                            input logic rw, input logic u, input logic l, input int ext_at);
        logic [2:0] exp_trip;
        logic [2:0] trip;
        logic [1:0] reg_seen;
        int         exp_edge;
        int         exp_reg;
        int         n;
        int         obs_edge;
        logic       p;
        logic       done;
        model(f, a, rw, ext_at, exp_trip, exp_edge, exp_reg);
        fc = f; addr = a; rw_n = rw; uds_n = u; lds_n = l; as_n = 1'b0;
        n = 0; obs_edge = 0; done = 1'b0; trip = T_IDLE; reg_seen = region;
        if (ext_at != 0 && ext_at <= 1) ext_dtack_n = 1'b0;
        while (!done && n <= TIMEOUT + 4) begin
            @(posedge clk);
            p = phi2;
            if (p) n++;
            @(negedge clk);
            trip = {dtack_n, vpa_n, berr};
            if (trip !== T_IDLE) begin
                done     = 1'b1;
                obs_edge = p ? n : -1;
                reg_seen = region;
            end else if (ext_at != 0 && n + 1 >= ext_at) begin
                ext_dtack_n = 1'b0;
            end
        end
        check({tag, " edge"}, obs_edge, exp_edge);
        check({tag, " resp"}, trip, exp_trip);
        if (exp_reg >= 0) check({tag, " region"}, reg_seen, exp_reg);
        repeat (6) @(negedge clk);
        check({tag, " hold"}, {dtack_n, vpa_n, berr}, exp_trip);
        $display("cycle %s fc=%0d addr=%06h rw=%0b ext_at=%0d -> resp=%03b at phi2 #%0d (exp %03b #%0d)",
                 tag, f, a, rw, ext_at, trip, obs_edge, exp_trip, exp_edge);
        release_check(tag);
    endtask

    initial begin
        int          k;
        logic [2:0]  f;
        logic [23:0] a;
        logic        rw;
        logic        u;
        logic        l;
        int          cls;
        int          ext_at;

        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", {dtack_n, vpa_n, berr, region}, 5'b11000);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cycles.
        do_cycle("ram_rd",    3'd5, 24'h001000, 1'b1, 1'b0, 1'b0, 0);
        do_cycle("rom_rd",    3'd6, 24'hFC0010, 1'b1, 1'b0, 1'b0, 0);
        do_cycle("rom_wr",    3'd5, 24'hFC0010, 1'b0, 1'b0, 1'b0, 0);
        do_cycle("iack",      3'd7, 24'hFFFFF9, 1'b1, 1'b1, 1'b0, 0);
        do_cycle("acia",      3'd5, 24'hFFFC00, 1'b1, 1'b1, 1'b0, 0);
        do_cycle("user_prot", 3'd1, 24'h000400, 1'b1, 1'b0, 1'b0, 0);
        do_cycle("unmapped",  3'd5, 24'hE00000, 1'b1, 1'b0, 1'b0, 0);
        do_cycle("ext_64",    3'd5, 24'hFF8800, 1'b1, 1'b0, 1'b0, 64);
        do_cycle("ext_65",    3'd5, 24'hFF8800, 1'b1, 1'b0, 1'b0, 65);

        // A write without data strobes must not start a cycle.
        fc = 3'd5; addr = 24'h001000; rw_n = 1'b0; uds_n = 1'b1; lds_n = 1'b1; as_n = 1'b0;
        repeat (12) @(negedge clk);
        check("nostrobe idle", {dtack_n, vpa_n, berr}, T_IDLE);
        do_cycle("late_strobe_wr", 3'd5, 24'h001000, 1'b0, 1'b1, 1'b0, 0);

        // Abort in mid-WAIT: AS rises before the timeout.
        fc = 3'd5; addr = 24'hE00000; rw_n = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        k = 0;
        for (int c = 0; c < 200 && k < 40; c++) begin
            @(posedge clk);
            if (phi2) k++;
            @(negedge clk);
        end
        check("abort waiting", {dtack_n, vpa_n, berr}, T_IDLE);
        release_check("abort");
        do_cycle("post_abort", 3'd5, 24'h002000, 1'b1, 1'b0, 1'b0, 0);

        // Reset pulled low while the cycle is acknowledged.
        fc = 3'd5; addr = 24'h003000; rw_n = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        for (int c = 0; c < 20 && dtack_n !== 1'b0; c++) @(negedge clk);
        check("rstack dtack", dtack_n, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstack cleared", {dtack_n, vpa_n, berr, region}, 5'b11000);
        reset_n = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(negedge clk);
        do_cycle("post_reset", 3'd6, 24'hFD1234, 1'b1, 1'b0, 1'b0, 0);

        // Randomized cycles across all regions.
        for (int i = 0; i < 40; i++) begin
            f   = 3'($urandom_range(0, 7));
            cls = $urandom_range(0, 6);
            case (cls)
                0: a = 24'($urandom) & 24'h3FFFFF;
                1: a = {8'(8'hFC + $urandom_range(0, 2)), 16'($urandom)};
                2: a = 24'hFFFC00 + 24'($urandom_range(0, 'h1FF));
                3: a = 24'hFF8000 + 24'($urandom_range(0, 'h7FFF));
                4: a = {8'(8'h40 + $urandom_range(0, 'hBB)), 16'($urandom)};
                5: begin
                    a = 24'hFFFFF0 | 24'($urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 1) f = 3'd7;
                end
                default: a = 24'($urandom_range(0, 'h7FF));
            endcase
            rw = 1'($urandom_range(0, 1));
            if (rw) begin
                u = 1'($urandom_range(0, 1));
                l = 1'($urandom_range(0, 1));
            end else begin
                k = $urandom_range(0, 2);
                u = (k == 0);
                l = (k == 1);
            end
            ext_at = $urandom_range(0, 70);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            do_cycle($sformatf("rnd%0d", i), f, a, rw, u, l, ext_at);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
